// File: rtl/multicycle_ctrl_pkg.sv
// Shared state encoding and next-state logic for the RV32I multi-cycle sequencer.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    // An ack wins over watchdog expiry in the same cycle.
    function automatic state_e next_state(
        input state_e cur,
        input logic   imem_ack,
        input logic   dmem_ack,
        input logic   load,
        input logic   store,
        input logic   halt,
        input logic   expired
    );
        state_e nxt;
        nxt = cur;
        case (cur)
            ST_IDLE:   nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    nxt = ST_DECODE;
                end else if (expired) begin
                    nxt = ST_FAULT;
                end else begin
                    nxt = ST_FETCH;
                end
            end
            ST_DECODE: nxt = ST_EXEC;
            ST_EXEC: begin
                if (load && store) begin
                    nxt = ST_FAULT;
                end else if (load || store) begin
                    nxt = ST_MEM;
                end else begin
                    nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    nxt = ST_WB;
                end else if (expired) begin
                    nxt = ST_FAULT;
                end else begin
                    nxt = ST_MEM;
                end
            end
            ST_WB: begin
                if (halt) begin
                    nxt = ST_HALT;
                end else begin
                    nxt = ST_FETCH;
                end
            end
            ST_HALT:   nxt = ST_HALT;
            ST_FAULT:  nxt = ST_FAULT;
            default:   nxt = ST_FAULT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles, flags when the count reaches the limit.
module mem_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Wait counter; clear has priority so every state entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (count_en) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == limit);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB strobes, watchdog and retire count.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255,
    parameter int RETIRE_W  = 32
) (
    input  logic                i_Clk_1,
    input  logic                i_RstN_1,
    output logic                o_IMemReq_1,
    input  logic                i_IMemAck_1,
    output logic                o_IRWen_1,
    input  logic                i_Load_1,
    input  logic                i_Store_1,
    input  logic                i_GRFWen_1,
    input  logic [4:0]          i_Rd_5,
    input  logic                i_Taken_1,
    input  logic                i_Halt_1,
    output logic                o_EXWen_1,
    output logic                o_DMemReq_1,
    output logic                o_DMemWe_1,
    input  logic                i_DMemAck_1,
    output logic                o_GRFWen_1,
    output logic                o_WBSelMem_1,
    output logic                o_PCWen_1,
    output logic                o_PCSel_1,
    output logic [2:0]          o_State_3,
    output logic                o_Halted_1,
    output logic                o_Fault_1,
    output logic [RETIRE_W-1:0] o_RetireCnt_32
);

    state_e                state_r;
    state_e                state_nxt_s;
    logic                  expired_s;
    logic                  wd_clear_s;
    logic                  wd_count_en_s;
    logic                  imem_req_r;
    logic                  ex_wen_r;
    logic                  dmem_req_r;
    logic                  wb_r;
    logic                  halted_r;
    logic                  fault_r;
    logic [RETIRE_W-1:0]   retire_r;

    // Next state and watchdog control.
    always_comb begin
        state_nxt_s   = next_state(state_r, i_IMemAck_1, i_DMemAck_1, i_Load_1,
                                   i_Store_1, i_Halt_1, expired_s);
        wd_clear_s    = (state_nxt_s != state_r);
        wd_count_en_s = ((state_r == ST_FETCH) && !i_IMemAck_1) ||
                        ((state_r == ST_MEM)   && !i_DMemAck_1);
    end

    mem_wait_timer #(
        .W(TIMEOUT_W)
    ) u_mem_wait_timer (
        .clk      (i_Clk_1),
        .rst_n    (i_RstN_1),
        .clear    (wd_clear_s),
        .count_en (wd_count_en_s),
        .limit    (TIMEOUT_W'(TIMEOUT)),
        .expired  (expired_s)
    );

    // Sequencer state, state-decoded strobes (registered from next state) and retire counter.
    always_ff @(posedge i_Clk_1) begin
        if (!i_RstN_1) begin
            state_r    <= ST_IDLE;
            imem_req_r <= 1'b0;
            ex_wen_r   <= 1'b0;
            dmem_req_r <= 1'b0;
            wb_r       <= 1'b0;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
            retire_r   <= {RETIRE_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            imem_req_r <= (state_nxt_s == ST_FETCH);
            ex_wen_r   <= (state_nxt_s == ST_EXEC);
            dmem_req_r <= (state_nxt_s == ST_MEM);
            wb_r       <= (state_nxt_s == ST_WB);
            halted_r   <= (state_nxt_s == ST_HALT);
            fault_r    <= (state_nxt_s == ST_FAULT);
            if (state_r == ST_WB) begin
                retire_r <= retire_r + RETIRE_W'(1);
            end else begin
                retire_r <= retire_r;
            end
        end
    end

    // Decode inputs are held stable from DECODE through WB, so qualifying them here is glitch-safe.
    assign o_IMemReq_1    = imem_req_r;
    assign o_IRWen_1      = imem_req_r & i_IMemAck_1;
    assign o_EXWen_1      = ex_wen_r;
    assign o_DMemReq_1    = dmem_req_r;
    assign o_DMemWe_1     = dmem_req_r & i_Store_1;
    assign o_GRFWen_1     = wb_r & (i_GRFWen_1 | i_Load_1) & (i_Rd_5 != 5'd0);
    assign o_WBSelMem_1   = wb_r & i_Load_1;
    assign o_PCWen_1      = wb_r;
    assign o_PCSel_1      = wb_r & i_Taken_1;
    assign o_State_3      = state_r;
    assign o_Halted_1     = halted_r;
    assign o_Fault_1      = fault_r;
    assign o_RetireCnt_32 = retire_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs queued and checked after each edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        grf_in = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        taken = 1'b0;
    logic        halt = 1'b0;

    logic        imem_req, ir_wen, ex_wen, dmem_req, dmem_we, grf_wen;
    logic        wb_sel, pc_wen, pc_sel, halted, fault;
    logic [2:0]  state;
    logic [31:0] retire;

    typedef logic [13:0] obs_t;
    obs_t obs_s;

    obs_t  exp_q[$];
    string tag_q[$];
    int    compared = 0;
    int    mism = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .i_Clk_1        (clk),
        .i_RstN_1       (rstn),
        .o_IMemReq_1    (imem_req),
        .i_IMemAck_1    (imem_ack),
        .o_IRWen_1      (ir_wen),
        .i_Load_1       (load),
        .i_Store_1      (store),
        .i_GRFWen_1     (grf_in),
        .i_Rd_5         (rd),
        .i_Taken_1      (taken),
        .i_Halt_1       (halt),
        .o_EXWen_1      (ex_wen),
        .o_DMemReq_1    (dmem_req),
        .o_DMemWe_1     (dmem_we),
        .i_DMemAck_1    (dmem_ack),
        .o_GRFWen_1     (grf_wen),
        .o_WBSelMem_1   (wb_sel),
        .o_PCWen_1      (pc_wen),
        .o_PCSel_1      (pc_sel),
        .o_State_3      (state),
        .o_Halted_1     (halted),
        .o_Fault_1      (fault),
        .o_RetireCnt_32 (retire)
    );

    // Layout: state | imreq irwen exwen dmreq dmwe grfwen wbsel pcwen pcsel halted fault
    assign obs_s = {state, imem_req, ir_wen, ex_wen, dmem_req, dmem_we,
                    grf_wen, wb_sel, pc_wen, pc_sel, halted, fault};

    function automatic obs_t mk(input logic [2:0] st, input logic [10:0] f);
        return {st, f};
    endfunction
    function automatic obs_t e_idle();   return mk(3'd0, 11'b000_0000_0000); endfunction
    function automatic obs_t e_fetch(input logic ack); return mk(3'd1, {1'b1, ack, 9'd0}); endfunction
    function automatic obs_t e_dec();    return mk(3'd2, 11'b000_0000_0000); endfunction
    function automatic obs_t e_exec();   return mk(3'd3, 11'b001_0000_0000); endfunction
    function automatic obs_t e_mem(input logic we); return mk(3'd4, {3'b000, 1'b1, we, 6'd0}); endfunction
    function automatic obs_t e_wb(input logic g, input logic w, input logic p);
        return mk(3'd5, {5'd0, g, w, 1'b1, p, 2'b00});
    endfunction
    function automatic obs_t e_halt();   return mk(3'd6, 11'b000_0000_0010); endfunction
    function automatic obs_t e_fault();  return mk(3'd7, 11'b000_0000_0001); endfunction

    task automatic step(input string tag, input obs_t e);
        obs_t  want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        compared++;
        assert (obs_s === want) else begin
            mism++;
            $error("FAIL %s: observed=%h expected=%h", t, obs_s, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_retire(input string tag, input logic [31:0] want);
        #1;
        compared++;
        assert (retire === want) else begin
            mism++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, retire, want);
        end
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic gw,
                           input logic [4:0] r, input logic tk, input logic hl);
        load = ld; store = st; grf_in = gw; rd = r; taken = tk; halt = hl;
    endtask

    task automatic instr(input string nm, input int dwait,
                         input logic xg, input logic xw, input logic xp);
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        step({nm, "_fetch"}, e_fetch(1'b1));
        step({nm, "_decode"}, e_dec());
        step({nm, "_exec"}, e_exec());
        if (load || store) begin
            for (int i = 0; i < dwait; i++) step({nm, "_memwait"}, e_mem(store));
            dmem_ack = 1'b1;
            step({nm, "_memack"}, e_mem(store));
        end
        step({nm, "_wb"}, e_wb(xg, xw, xp));
    endtask

    task automatic do_reset(input string nm, input obs_t cur);
        rstn = 1'b0;
        step({nm, "_pre"}, cur);
        rstn = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        step({nm, "_idle"}, e_idle());
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk_retire("reset_retire", 32'd0);
        imem_ack = 1'b1;
        step("reset_idle", e_idle());

        set_dec(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        instr("addi", 0, 1'b1, 1'b0, 1'b0);
        chk_retire("addi_retire", 32'd1);

        set_dec(1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        instr("lw", 3, 1'b1, 1'b1, 1'b0);
        chk_retire("lw_retire", 32'd2);

        set_dec(1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
        instr("sw", 0, 1'b0, 1'b0, 1'b0);
        set_dec(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        instr("beq", 0, 1'b0, 1'b0, 1'b1);
        set_dec(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        instr("addi_x0", 0, 1'b0, 1'b0, 1'b0);
        chk_retire("mix_retire", 32'd5);

        set_dec(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        instr("ebreak", 0, 1'b0, 1'b0, 1'b0);
        chk_retire("halt_retire", 32'd6);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        step("halt_hold0", e_halt());
        step("halt_hold1", e_halt());
        do_reset("rst_halt", e_halt());
        chk_retire("rst_retire", 32'd0);

        set_dec(1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        imem_ack = 1'b0;
        for (int i = 0; i < 256; i++) step("fetch_wait", e_fetch(1'b0));
        step("fetch_timeout", e_fault());
        imem_ack = 1'b1;
        step("fault_hold", e_fault());
        do_reset("rst_fault", e_fault());

        set_dec(1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        for (int i = 0; i < 255; i++) step("fetch_wait2", e_fetch(1'b0));
        imem_ack = 1'b1;
        step("fetch_ack_at_limit", e_fetch(1'b1));
        step("ldst_decode", e_dec());
        step("ldst_exec", e_exec());
        step("ldst_fault", e_fault());
        do_reset("rst_ldst", e_fault());

        set_dec(1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        step("mto_fetch", e_fetch(1'b1));
        step("mto_decode", e_dec());
        step("mto_exec", e_exec());
        dmem_ack = 1'b0;
        for (int i = 0; i < 256; i++) step("mem_wait", e_mem(1'b0));
        step("mem_timeout", e_fault());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
